// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFOs, runtime frame length, all four CPOL/CPHA modes,
// an integer SCLK divider, NUM_CS chip selects and optional CS hold across frames.
module spi_master_fifo #(
    parameter int MAX_FRAME  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CS     = 4,
    localparam int LW  = $clog2(MAX_FRAME) + 1,
    localparam int CSW = $clog2(NUM_CS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 lsb_first,
    input  logic [LW-1:0]        frame_len,
    input  logic [7:0]           clkdiv,
    input  logic [CSW-1:0]       cs_sel,
    input  logic                 cs_hold,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [MAX_FRAME-1:0] tx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [MAX_FRAME-1:0] rx_data,
    output logic                 rx_overflow,
    input  logic                 ovf_clr,
    output logic                 busy,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso,
    output logic [NUM_CS-1:0]    cs_n,
    output logic [2:0]           state_dbg
);
    // Handshakes: a word moves on exactly the cycles where valid && ready are both
    // high; valid never waits for ready, and a raised valid holds its data until taken.

    localparam int FW = $clog2(MAX_FRAME);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = LW + 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;
    state_t state;

    logic [MAX_FRAME-1:0] tx_mem [FIFO_DEPTH];
    logic [MAX_FRAME-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [AW:0]          tx_count, rx_count;
    logic                 tx_push, tx_pop, tx_empty, tx_full;
    logic                 rx_push, rx_pop, rx_wr, rx_full;
    logic [MAX_FRAME-1:0] tx_head;

    logic [MAX_FRAME-1:0] tx_word, rx_word, rx_sampled;
    logic                 l_cpol, l_cpha, l_lsb, l_hold;
    logic [LW-1:0]        l_n, bit_idx, new_n;
    logic [7:0]           l_div, cnt;
    logic [CSW-1:0]       l_cs;
    logic [EW-1:0]        edge_cnt, edge_num;
    logic                 half_end, edge_lead, last_edge, sample_now, start, chain;
    logic [FW-1:0]        cur_pos, next_pos, first_pos;

    function automatic logic [LW-1:0] norm_len(input logic [LW-1:0] len);
        if (len == '0 || len > LW'(MAX_FRAME)) return LW'(MAX_FRAME);
        return len;
    endfunction

    function automatic logic [FW-1:0] bit_pos(input logic lsb, input logic [LW-1:0] n,
                                              input logic [LW-1:0] idx);
        logic [LW-1:0] p;
        p = lsb ? idx : n - LW'(1) - idx;
        return p[FW-1:0];
    endfunction

    function automatic logic [NUM_CS-1:0] cs_mask(input logic [CSW-1:0] sel);
        logic [NUM_CS-1:0] m;
        m      = '1;
        m[sel] = 1'b0;
        return m;
    endfunction

    assign tx_empty  = (tx_count == '0);
    assign tx_full   = (tx_count == DEPTH_C);
    assign tx_ready  = !tx_full;
    assign tx_push   = tx_valid && tx_ready;
    assign tx_head   = tx_mem[tx_rptr];
    assign rx_full   = (rx_count == DEPTH_C);
    assign rx_valid  = (rx_count != '0);
    assign rx_pop    = rx_valid && rx_ready;
    assign rx_data   = rx_mem[rx_rptr];
    assign state_dbg = state;

    assign half_end   = (cnt == l_div);
    assign edge_num   = edge_cnt + EW'(1);
    assign edge_lead  = edge_num[0];
    assign last_edge  = (edge_num == {l_n, 1'b0});
    // Leading edges are the odd ones; cpha picks which edge class samples miso.
    assign sample_now = (state == XFER) && half_end && (edge_lead ^ l_cpha);
    assign cur_pos    = bit_pos(l_lsb, l_n, bit_idx);
    assign next_pos   = bit_pos(l_lsb, l_n, bit_idx + LW'(1));
    assign new_n      = norm_len(frame_len);
    assign first_pos  = bit_pos(lsb_first, new_n, '0);

    assign rx_push = (state == XFER) && half_end && last_edge;
    assign rx_wr   = rx_push && (!rx_full || rx_pop);
    assign start   = (state == IDLE) && !tx_empty;
    assign chain   = rx_push && l_hold && !tx_empty && (cs_sel == l_cs);
    assign tx_pop  = start || chain;

    always_comb begin
        rx_sampled = rx_word;
        if (sample_now) rx_sampled[cur_pos] = miso;
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= tx_data;
        if (rx_wr)   rx_mem[rx_wptr] <= rx_sampled;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + (AW+1)'(1);
            else if (!tx_push && tx_pop) tx_count <= tx_count - (AW+1)'(1);
            if (rx_wr)  rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop) rx_rptr <= rx_rptr + AW'(1);
            if (rx_wr && !rx_pop)      rx_count <= rx_count + (AW+1)'(1);
            else if (!rx_wr && rx_pop) rx_count <= rx_count - (AW+1)'(1);
            if (rx_push && !rx_wr) rx_overflow <= 1'b1;
            else if (ovf_clr)      rx_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= '1;
            busy     <= 1'b0;
            cnt      <= '0;
            edge_cnt <= '0;
            bit_idx  <= '0;
            tx_word  <= '0;
            rx_word  <= '0;
            l_cpol   <= 1'b0;
            l_cpha   <= 1'b0;
            l_lsb    <= 1'b0;
            l_hold   <= 1'b0;
            l_n      <= '0;
            l_div    <= '0;
            l_cs     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sclk <= cpol;
                    cs_n <= '1;
                    if (start) begin
                        state <= SETUP;
                        busy  <= 1'b1;
                        cs_n  <= cs_mask(cs_sel);
                    end
                end
                SETUP: begin
                    if (half_end) begin
                        state <= XFER;
                        cnt   <= '0;
                    end else cnt <= cnt + 8'd1;
                end
                XFER: begin
                    if (half_end) begin
                        cnt      <= '0;
                        edge_cnt <= edge_num;
                        rx_word  <= rx_sampled;
                        if (!edge_lead) bit_idx <= bit_idx + LW'(1);
                        if (last_edge) begin
                            sclk  <= l_cpol;
                            state <= chain ? XFER : HOLD;
                        end else begin
                            sclk <= ~sclk;
                            if (!l_cpha && !edge_lead) mosi <= tx_word[next_pos];
                            if (l_cpha && edge_lead)   mosi <= tx_word[cur_pos];
                        end
                    end else cnt <= cnt + 8'd1;
                end
                HOLD: begin
                    if (half_end) begin
                        state <= GAP;
                        cs_n  <= '1;
                        cnt   <= '0;
                    end else cnt <= cnt + 8'd1;
                end
                GAP: begin
                    if (half_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else cnt <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
            // Loading a new word (fresh start or CS-held chain) overrides the counters above.
            if (tx_pop) begin
                tx_word  <= tx_head;
                l_cpol   <= cpol;
                l_cpha   <= cpha;
                l_lsb    <= lsb_first;
                l_hold   <= cs_hold;
                l_n      <= new_n;
                l_div    <= clkdiv;
                l_cs     <= cs_sel;
                cnt      <= '0;
                edge_cnt <= '0;
                bit_idx  <= '0;
                rx_word  <= '0;
                sclk     <= cpol;
                if (!cpha) mosi <= tx_head[first_pos];
            end
        end
    end
endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: all four modes, frame-length boundaries,
// CS hold chaining, RX overflow, TX back-pressure and mid-frame reset.
module tb_spi_master_fifo;
    logic        clk = 1'b0;
    logic        rst, cpol, cpha, lsb_first, cs_hold, tx_valid, rx_ready, ovf_clr;
    logic [5:0]  frame_len;
    logic [7:0]  clkdiv;
    logic [1:0]  cs_sel;
    logic [31:0] tx_data, rx_data;
    logic        tx_ready, rx_valid, rx_overflow, busy, sclk, mosi, miso;
    logic [3:0]  cs_n;
    logic [2:0]  state_dbg;
    logic        loop_en, miso_val;

    assign miso = loop_en ? mosi : miso_val;

    spi_master_fifo dut (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .frame_len(frame_len), .clkdiv(clkdiv), .cs_sel(cs_sel), .cs_hold(cs_hold),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_overflow(rx_overflow), .ovf_clr(ovf_clr), .busy(busy),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor, sampled on the falling clk edge.
    int          cyc = 0, edges, cs_low, cs_falls, bad_cs, hp_min, hp_max, last_tog;
    logic [63:0] mosi_seq;
    logic        sclk_prev, mon_clr = 1'b0;
    logic [3:0]  cs_prev, exp_cs;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        sclk_prev <= sclk;
        cs_prev   <= cs_n;
        if (mon_clr) begin
            edges    <= 0;
            cs_low   <= 0;
            cs_falls <= 0;
            bad_cs   <= 0;
            hp_min   <= 1000;
            hp_max   <= 0;
            last_tog <= -1;
            mosi_seq <= '0;
        end else begin
            if (sclk !== sclk_prev) begin
                edges <= edges + 1;
                if (sclk) mosi_seq <= {mosi_seq[62:0], mosi};
                if (last_tog >= 0) begin
                    if (cyc - last_tog < hp_min) hp_min <= cyc - last_tog;
                    if (cyc - last_tog > hp_max) hp_max <= cyc - last_tog;
                end
                last_tog <= cyc;
            end
            if (cs_n != 4'hF) cs_low <= cs_low + 1;
            if (cs_n != 4'hF && cs_prev == 4'hF) cs_falls <= cs_falls + 1;
            if (cs_n != 4'hF && cs_n != exp_cs) bad_cs <= bad_cs + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        int t = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (!tx_ready && t < 2000) begin
            tick(1);
            t++;
        end
        if (!tx_ready) check("push_timeout", tx_ready, 1'b1);
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int quiet = 0;
        int t = 0;
        while (quiet < 3 && t < budget) begin
            @(negedge clk);
            if (!busy) quiet++;
            else quiet = 0;
            t++;
        end
        if (quiet < 3) check("done_timeout", busy, 1'b0);
        tick(1);
    endtask

    task automatic pop_check(input string tag);
        int t = 0;
        logic [31:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_0000;
        while (!rx_valid && t < 2000) begin
            tick(1);
            t++;
        end
        check({tag, "_valid"}, rx_valid, 1'b1);
        check(tag, rx_data, exp);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic config_bus(input logic pol, input logic pha, input logic lsb,
                              input logic [5:0] len, input logic [7:0] div);
        cpol = pol; cpha = pha; lsb_first = lsb; frame_len = len; clkdiv = div;
        tick(3);
    endtask

    initial begin
        rst = 1'b1; cpol = 0; cpha = 0; lsb_first = 0; frame_len = 6'd8; clkdiv = 0;
        cs_sel = 0; cs_hold = 0; tx_valid = 0; tx_data = 0; rx_ready = 0; ovf_clr = 0;
        loop_en = 1'b1; miso_val = 1'b0; exp_cs = 4'b1110;
        tick(3);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_overflow", rx_overflow, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cs_n", cs_n, 4'hF);
        check("rst_mosi", mosi, 1'b0);
        check("rst_sclk", sclk, 1'b0);
        check("rst_state", state_dbg, 3'd0);
        rst = 1'b0;
        tick(2);

        // Mode 0, 8 bits, MSB first, loopback.
        config_bus(0, 0, 0, 6'd8, 8'd0);
        clear_mon();
        push(32'h72);
        exp_q.push_back(32'h0000_0072);
        wait_done(200);
        check("m0_edges", edges, 16);
        check("m0_mosi_seq", mosi_seq, 64'h72);
        check("m0_cs_low", cs_low, 18);
        check("m0_cs_falls", cs_falls, 1);
        check("m0_bad_cs", bad_cs, 0);
        pop_check("m0_rx");

        // Mode 3, 16 bits, LSB first, divider 3, miso high.
        loop_en = 1'b0; miso_val = 1'b1;
        config_bus(1, 1, 1, 6'd16, 8'd3);
        check("m3_sclk_idle", sclk, 1'b1);
        clear_mon();
        push(32'hA5C3);
        exp_q.push_back(32'h0000_FFFF);
        wait_done(400);
        check("m3_edges", edges, 32);
        check("m3_hp_min", hp_min, 4);
        check("m3_hp_max", hp_max, 4);
        check("m3_mosi_seq", mosi_seq, 64'hC3A5);
        check("m3_first_bit", mosi_seq[15], 1'b1);
        check("m3_cs_low", cs_low, 136);
        check("m3_sclk_end", sclk, 1'b1);
        pop_check("m3_rx");

        // Mode 1, frame_len 0 means a full 32-bit frame, loopback.
        loop_en = 1'b1;
        config_bus(0, 1, 0, 6'd0, 8'd0);
        clear_mon();
        push(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        wait_done(300);
        check("m1_edges", edges, 64);
        check("m1_mosi_seq", mosi_seq, 64'hDEADBEEF);
        check("m1_cs_low", cs_low, 66);
        pop_check("m1_rx");

        // Mode 2, frame_len 40 clamps to 32, divider 1, miso high.
        loop_en = 1'b0; miso_val = 1'b1;
        config_bus(1, 0, 0, 6'd40, 8'd1);
        clear_mon();
        push(32'h12345678);
        exp_q.push_back(32'hFFFF_FFFF);
        wait_done(400);
        check("m2_edges", edges, 64);
        check("m2_cs_low", cs_low, 132);
        check("m2_sclk_end", sclk, 1'b1);
        pop_check("m2_rx");

        // CS hold across three frames on cs 2.
        loop_en = 1'b1; cs_sel = 2'd2; cs_hold = 1'b1;
        config_bus(0, 0, 0, 6'd8, 8'd0);
        exp_cs = 4'b1011;
        clear_mon();
        push(32'h11); push(32'h22); push(32'h33);
        exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h33);
        wait_done(500);
        check("hold_cs_falls", cs_falls, 1);
        check("hold_bad_cs", bad_cs, 0);
        check("hold_edges", edges, 48);
        pop_check("hold_rx0");
        pop_check("hold_rx1");
        pop_check("hold_rx2");
        check("hold_rx_empty", rx_valid, 1'b0);
        cs_hold = 1'b0; cs_sel = 2'd0; exp_cs = 4'b1110;
        tick(2);

        // RX overflow: five frames with nobody popping.
        clear_mon();
        for (int i = 1; i <= 5; i++) push(32'hA0 + 32'(i));
        for (int i = 1; i <= 4; i++) exp_q.push_back(32'hA0 + 32'(i));
        wait_done(1000);
        check("ovf_set", rx_overflow, 1'b1);
        check("ovf_rx_valid", rx_valid, 1'b1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_clr", rx_overflow, 1'b0);
        for (int i = 0; i < 4; i++) pop_check("ovf_rx");
        check("ovf_rx_empty", rx_valid, 1'b0);

        // TX back-pressure with a slow frame in flight.
        config_bus(0, 0, 0, 6'd8, 8'd7);
        for (int i = 1; i <= 5; i++) begin
            push(32'hB0 + 32'(i));
            exp_q.push_back(32'hB0 + 32'(i));
            if (i == 4) check("txfull_ready_4", tx_ready, 1'b1);
            if (i == 5) check("txfull_ready_5", tx_ready, 1'b0);
        end
        for (int i = 0; i < 5; i++) pop_check("txfull_rx");
        wait_done(500);
        check("txfull_no_dup", rx_valid, 1'b0);
        check("txfull_no_ovf", rx_overflow, 1'b0);
        check("txfull_ready_end", tx_ready, 1'b1);

        // Reset in the middle of a 32-bit frame with a second word queued.
        config_bus(0, 0, 0, 6'd32, 8'd0);
        push(32'hCAFEF00D);
        push(32'h1234);
        tick(20);
        check("mid_busy_pre", busy, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_cs_n", cs_n, 4'hF);
        check("mid_sclk", sclk, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_tx_ready", tx_ready, 1'b1);
        check("mid_rx_valid", rx_valid, 1'b0);
        check("mid_state", state_dbg, 3'd0);
        tick(10);
        check("mid_tx_empty", busy, 1'b0);
        check("mid_rx_empty", rx_valid, 1'b0);
        check("all_bad_cs", bad_cs, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
